// File: rtl/s2p.sv
// Serial-to-parallel receiver, LSB first, ready/valid on both sides.
// Define S2P_PARITY_EN to add a trailing even-parity beat per word.
module s2p #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  input  logic         s_data,
  output logic         s_ready,
  output logic         p_valid,
  output logic [N-1:0] p_data,
  output logic         p_err,
  input  logic         p_ready
);

`ifdef S2P_PARITY_EN
  localparam int L = N + 1;
`else
  localparam int L = N;
`endif
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(L - 1);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] HOLD    = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  sr_q, sr_d;
  logic [N-1:0]  shift, word;
  logic          pv_q, pv_d;
  logic [N-1:0]  pd_q, pd_d;
  logic          last, load, drain;
`ifdef S2P_PARITY_EN
  logic          par_q, par_d;
  logic          pe_q, pe_d;
  logic          werr;
`endif

  assign shift = {s_data, sr_q[N-1:1]};
  assign last  = (cnt_q == LAST);
  assign drain = pv_q && p_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    word    = '0;
    load    = 1'b0;
`ifdef S2P_PARITY_EN
    par_d   = par_q;
    werr    = 1'b0;
`endif
    unique case (state_q)
      COLLECT: begin
        if (s_valid) begin
          cnt_d = last ? '0 : cnt_q + 1'b1;
`ifdef S2P_PARITY_EN
          // Parity beat is folded into par_q, never into sr.
          sr_d  = last ? sr_q : shift;
          par_d = (cnt_q == '0) ? s_data : (par_q ^ s_data);
          word  = sr_q;
          werr  = par_q ^ s_data;
`else
          sr_d  = shift;
          word  = shift;
`endif
          if (last) begin
            if (!pv_q || p_ready) begin
              load = 1'b1;
            end else begin
              state_d = HOLD;
            end
          end
        end
      end
      HOLD: begin
        word = sr_q;
`ifdef S2P_PARITY_EN
        werr = par_q;
`endif
        if (drain) begin
          load    = 1'b1;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    pv_d = pv_q;
    pd_d = pd_q;
`ifdef S2P_PARITY_EN
    pe_d = pe_q;
`endif
    if (load) begin
      pv_d = 1'b1;
      pd_d = word;
`ifdef S2P_PARITY_EN
      pe_d = werr;
`endif
    end else if (drain) begin
      pv_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      sr_q    <= '0;
      pv_q    <= 1'b0;
      pd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      pv_q    <= pv_d;
      pd_q    <= pd_d;
    end
  end

`ifdef S2P_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
      pe_q  <= 1'b0;
    end else begin
      par_q <= par_d;
      pe_q  <= pe_d;
    end
  end

  assign p_err = pe_q;
`else
  assign p_err = 1'b0;
`endif

  assign s_ready = (state_q == COLLECT);
  assign p_valid = pv_q;
  assign p_data  = pd_q;

endmodule

// File: tb/tb_s2p.sv
// Scoreboard bench for s2p: stimulus pushes expected words,
// a negedge monitor pops them on each parallel transfer.
module tb_s2p;

  localparam int N = 8;
`ifdef S2P_PARITY_EN
  localparam int L = N + 1;
`else
  localparam int L = N;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_data = 1'b0;
  logic         s_ready;
  logic         p_valid;
  logic [N-1:0] p_data;
  logic         p_err;
  logic         p_ready = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int sr_low = 0;
  bit watch  = 1'b0;

  logic [N:0] exp_q[$];
  int         pop_cyc[$];

  s2p #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .p_valid (p_valid),
    .p_data  (p_data),
    .p_err   (p_err),
    .p_ready (p_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens on the coming posedge.
  always @(negedge clk) begin
    if (watch && !s_ready) sr_low++;
    if (!rst && p_valid && p_ready) begin
      logic [N:0] e;
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_word: got %0h expected none", p_data);
      end else begin
        e = exp_q.pop_front();
        check("p_data", int'(p_data), int'(e[N-1:0]));
        check("p_err", int'(p_err), int'(e[N]));
      end
    end
  end

  task automatic send_bit(input logic b);
    int n;
    s_valid = 1'b1;
    s_data  = b;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n > 200) begin
        n_chk++;
        n_fail++;
        $display("FAIL s_ready_timeout: got 0 expected 1");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [N-1:0] d, input logic pb);
    logic e;
`ifdef S2P_PARITY_EN
    e = (^d) ^ pb;
`else
    e = 1'b0;
`endif
    exp_q.push_back({e, d});
    for (int i = 0; i < N; i++) send_bit(d[i]);
`ifdef S2P_PARITY_EN
    send_bit(pb);
`endif
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [N-1:0] v;
    #3;
    check("rst_s_ready", int'(s_ready), 1);
    check("rst_p_valid", int'(p_valid), 0);
    check("rst_p_data", int'(p_data), 0);
    check("rst_p_err", int'(p_err), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single word 4D, LSB first.
    p_ready = 1'b1;
    watch = 1'b1;
    sr_low = 0;
    v = 8'h4D;
    send_word(v, ^v);
    check("lat_p_valid", int'(p_valid), 1);
    check("lat_p_data", int'(p_data), 8'h4D);
    idle(1);
    check("one_cycle_valid", int'(p_valid), 0);
    check("t1_s_ready_low", sr_low, 0);

    // Back-to-back A5, 3C.
    idle(2);
    pop_cyc.delete();
    sr_low = 0;
    v = 8'hA5;
    send_word(v, ^v);
    v = 8'h3C;
    send_word(v, ^v);
    idle(3);
    watch = 1'b0;
    check("b2b_pops", pop_cyc.size(), 2);
    if (pop_cyc.size() == 2)
      check("b2b_spacing", pop_cyc[1] - pop_cyc[0], L);
    check("b2b_s_ready_low", sr_low, 0);

    // Backpressure with 11, 22, 33.
    p_ready = 1'b0;
    pop_cyc.delete();
    v = 8'h11;
    send_word(v, ^v);
    v = 8'h22;
    send_word(v, ^v);
    check("bp_s_ready", int'(s_ready), 0);
    idle(2);
    check("bp_hold_valid", int'(p_valid), 1);
    check("bp_hold_data", int'(p_data), 8'h11);
    check("bp_still_stalled", int'(s_ready), 0);
    fork
      begin
        v = 8'h33;
        send_word(v, ^v);
      end
      begin
        repeat (3) @(posedge clk);
        #1 p_ready = 1'b1;
      end
    join
    idle(3);
    check("bp_pops", pop_cyc.size(), 3);
    if (pop_cyc.size() == 3)
      check("bp_22_next_edge", pop_cyc[1] - pop_cyc[0], 1);

    // Gaps inside F0.
    v = 8'hF0;
    exp_q.push_back({1'b0, v});
    for (int i = 0; i < N; i++) begin
      send_bit(v[i]);
      idle(int'($urandom_range(0, 3)));
    end
`ifdef S2P_PARITY_EN
    send_bit(1'b0);
`endif
    idle(3);
    check("gap_drained", exp_q.size(), 0);

    // Reset mid-word, then 81.
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_s_ready", int'(s_ready), 1);
    check("mid_rst_p_valid", int'(p_valid), 0);
    check("mid_rst_p_data", int'(p_data), 0);
    check("mid_rst_p_err", int'(p_err), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1);
    v = 8'h81;
    send_word(v, ^v);
    idle(3);

`ifdef S2P_PARITY_EN
    pop_cyc.delete();
    send_word(8'h03, 1'b0);
    send_word(8'h07, 1'b0);
    idle(3);
    if (pop_cyc.size() == 2)
      check("par_spacing", pop_cyc[1] - pop_cyc[0], 9);
    else
      check("par_pops", pop_cyc.size(), 2);
`endif

    idle(5);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
